// File: rtl/fetch_queue.sv
// Fetch-to-issue instruction queue: circular buffer, entry visible one cycle after enqueue, no bypass.
// Backpressure: full (registered count == DEPTH) stalls fetch; head advances only when deq_ready is high.
module fetch_queue #(
  parameter int DEPTH = 4,
  parameter int CW    = 3
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          flush,
  input  logic          enq_valid,
  input  logic [31:0]   enq_instr,
  input  logic [31:0]   enq_pc,
  input  logic          enq_pred,
  output logic          full,
  input  logic          deq_ready,
  output logic          deq_valid,
  output logic [31:0]   deq_instr,
  output logic [31:0]   deq_pc,
  output logic          deq_pred,
  output logic [CW-1:0] count
);

  localparam int PW = $clog2(DEPTH);

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc;
    logic        pred;
  } entry_t;

  entry_t          mem_q [DEPTH];
  logic [PW-1:0]   head_q, head_d;
  logic [PW-1:0]   tail_q, tail_d;
  logic [CW-1:0]   count_q, count_d;
  logic            enq_fire, deq_fire;
  entry_t          head_ent;

  assign full      = (count_q == CW'(DEPTH));
  assign deq_valid = (count_q != '0);
  assign count     = count_q;

  assign enq_fire = enq_valid && !full && !flush;
  assign deq_fire = deq_valid && deq_ready && !flush;

  // Stale storage is never exposed: outputs are zeroed whenever the queue is empty.
  assign head_ent  = mem_q[head_q];
  assign deq_instr = deq_valid ? head_ent.instr : 32'h0;
  assign deq_pc    = deq_valid ? head_ent.pc    : 32'h0;
  assign deq_pred  = deq_valid ? head_ent.pred  : 1'b0;

  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    if (flush) begin
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end else begin
      if (enq_fire) tail_d = tail_q + PW'(1);
      if (deq_fire) head_d = head_q + PW'(1);
      if (enq_fire && !deq_fire)      count_d = count_q + CW'(1);
      else if (deq_fire && !enq_fire) count_d = count_q - CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (reset && enq_fire) begin
      mem_q[tail_q] <= '{instr: enq_instr, pc: enq_pc, pred: enq_pred};
    end
  end

endmodule

// File: tb/tb_fetch_queue.sv
module tb_fetch_queue;

  localparam int DEPTH = 4;
  localparam int CW    = 3;

  logic          clk = 1'b0;
  logic          reset, flush, enq_valid, enq_pred, deq_ready;
  logic [31:0]   enq_instr, enq_pc;
  logic          full, deq_valid, deq_pred;
  logic [31:0]   deq_instr, deq_pc;
  logic [CW-1:0] count;

  fetch_queue #(.DEPTH(DEPTH), .CW(CW)) dut (
    .clk(clk), .reset(reset), .flush(flush),
    .enq_valid(enq_valid), .enq_instr(enq_instr), .enq_pc(enq_pc), .enq_pred(enq_pred),
    .full(full), .deq_ready(deq_ready), .deq_valid(deq_valid),
    .deq_instr(deq_instr), .deq_pc(deq_pc), .deq_pred(deq_pred), .count(count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] instr;
    logic [31:0] pc;
    logic        pred;
  } ent_t;

  ent_t mq[$];
  int   checks = 0;
  int   errors = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Reference: a plain FIFO queue; outputs are the front element or zero when empty.
  task automatic check_model(input string tag);
    int n;
    n = mq.size();
    chk({tag, "_count"}, 32'(count), 32'(n));
    chk({tag, "_full"},  32'(full), 32'(n == DEPTH));
    chk({tag, "_vld"},   32'(deq_valid), 32'(n != 0));
    chk({tag, "_instr"}, deq_instr, (n != 0) ? mq[0].instr : 32'h0);
    chk({tag, "_pc"},    deq_pc,    (n != 0) ? mq[0].pc    : 32'h0);
    chk({tag, "_pred"},  32'(deq_pred), (n != 0) ? 32'(mq[0].pred) : 32'h0);
  endtask

  task automatic model_update();
    bit do_deq, do_enq;
    ent_t e;
    if (!reset || flush) begin
      mq.delete();
    end else begin
      do_deq = (mq.size() != 0) && deq_ready;
      do_enq = enq_valid && (mq.size() != DEPTH);
      if (do_deq) void'(mq.pop_front());
      if (do_enq) begin
        e.instr = enq_instr; e.pc = enq_pc; e.pred = enq_pred;
        mq.push_back(e);
      end
    end
  endtask

  task automatic tick(input string tag);
    check_model(tag);
    @(posedge clk);
    model_update();
    #1;
  endtask

  task automatic drive(input logic r, input logic f, input logic ev, input logic [31:0] ins,
                       input logic [31:0] pc, input logic pr, input logic dr);
    reset = r; flush = f; enq_valid = ev; enq_instr = ins; enq_pc = pc; enq_pred = pr; deq_ready = dr;
  endtask

  initial begin
    drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    mq.delete();
    drive(1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
    chk("rst_count", 32'(count), 32'h0);
    chk("rst_vld", 32'(deq_valid), 32'h0);
    chk("rst_full", 32'(full), 32'h0);
    chk("rst_pc", deq_pc, 32'h0);

    // Fill to full, then a dropped fifth enqueue.
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 1'b0, 1'b1, 32'h1000 + 32'(i), 32'(i * 4), 1'(i), 1'b0);
      tick("fill");
    end
    drive(1'b1, 1'b0, 1'b1, 32'hdead, 32'h10, 1'b1, 1'b0);
    tick("drop");
    chk("full_count", 32'(count), 32'd4);
    chk("full_flag", 32'(full), 32'h1);
    chk("full_head", deq_pc, 32'h0);

    // Drain in order.
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b1);
      chk("drain_pc", deq_pc, 32'(i * 4));
      tick("drain");
    end
    chk("drained_vld", 32'(deq_valid), 32'h0);
    chk("drained_count", 32'(count), 32'h0);

    // No bypass on empty queue.
    drive(1'b1, 1'b0, 1'b1, 32'h00500093, 32'h100, 1'b1, 1'b1);
    chk("nobyp_vld", 32'(deq_valid), 32'h0);
    tick("nobyp");
    chk("nobyp_vld1", 32'(deq_valid), 32'h1);
    chk("nobyp_instr", deq_instr, 32'h00500093);
    chk("nobyp_pc", deq_pc, 32'h100);
    chk("nobyp_pred", 32'(deq_pred), 32'h1);

    // count=2, then simultaneous enq/deq across pointer wrap.
    drive(1'b1, 1'b0, 1'b1, 32'h2222, 32'h104, 1'b0, 1'b0);
    tick("pre_wrap");
    for (int i = 0; i < 6; i++) begin
      drive(1'b1, 1'b0, 1'b1, 32'h3000 + 32'(i), 32'h20 + 32'(i * 4), 1'(i), 1'b1);
      tick("wrap");
    end
    chk("wrap_count", 32'(count), 32'd2);
    chk("wrap_head", deq_pc, 32'h30);

    // count=3, flush wins over same-cycle enqueue.
    drive(1'b1, 1'b0, 1'b1, 32'h4444, 32'h38, 1'b0, 1'b0);
    tick("pre_flush");
    drive(1'b1, 1'b1, 1'b1, 32'h9999, 32'h99, 1'b1, 1'b1);
    chk("flush_cycle_vld", 32'(deq_valid), 32'h1);
    tick("flush");
    chk("flush_count", 32'(count), 32'h0);
    chk("flush_vld", 32'(deq_valid), 32'h0);
    drive(1'b1, 1'b0, 1'b1, 32'h4040, 32'h40, 1'b0, 1'b0);
    tick("post_flush");
    chk("post_flush_pc", deq_pc, 32'h40);

    // count=2, mid-run reset discards a same-cycle enqueue.
    drive(1'b1, 1'b0, 1'b1, 32'h4444, 32'h44, 1'b1, 1'b0);
    tick("pre_rst");
    drive(1'b0, 1'b0, 1'b1, 32'h7777, 32'h77, 1'b1, 1'b0);
    tick("mid_rst");
    chk("mid_rst_count", 32'(count), 32'h0);
    chk("mid_rst_full", 32'(full), 32'h0);
    drive(1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
    tick("after_rst");
    chk("after_rst_vld", 32'(deq_valid), 32'h0);

    // Randomized traffic against the model.
    for (int i = 0; i < 500; i++) begin
      drive(($urandom_range(63) != 0), ($urandom_range(15) == 0), 1'($urandom),
            $urandom, $urandom, 1'($urandom), 1'($urandom));
      tick("rand");
    end
    drive(1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
    check_model("final");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
